// File: rtl/if_fetch_stage.sv
// Instruction-fetch front end: in-order imem requests, response PC tracking,
// and a small {pc, inst} FIFO presented to decode with redirect flushing.
module if_fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ds_allowin,
   input  logic        stall_flag,
   input  logic        br_taken,
   input  logic [31:0] br_target,
   input  logic        trap_valid,
   input  logic [31:0] trap_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        fs_valid,
   output logic [31:0] pc_out,
   output logic [31:0] inst_out
);

   localparam int            AW      = $clog2(DEPTH);
   localparam int            CW      = AW + 1;
   localparam logic [CW:0]   DEPTH_W = (CW+1)'(DEPTH);

   logic [31:0]   fetch_pc;
   logic [31:0]   resp_pc;
   logic [CW-1:0] outstanding;
   logic [CW-1:0] discard;
   logic [CW-1:0] wptr;
   logic [CW-1:0] rptr;
   logic [CW-1:0] count;
   logic [31:0]   fifo_pc   [DEPTH];
   logic [31:0]   fifo_inst [DEPTH];

   logic          redirect;
   logic [31:0]   target;
   logic          grant;
   logic          resp;
   logic          push;
   logic          pop;
   logic          empty;

   assign redirect = trap_valid | br_taken;
   assign target   = {(trap_valid ? trap_target[31:2] : br_target[31:2]), 2'b00};

   assign count    = wptr - rptr;
   assign empty    = (count == '0);

   // Every in-flight request holds a FIFO slot, so a response can always be pushed.
   assign imem_req  = !rst && !redirect &&
                      (({1'b0, outstanding} + {1'b0, count}) < DEPTH_W);
   assign imem_addr = fetch_pc;
   assign grant     = imem_req & imem_gnt;

   assign resp      = imem_rvalid && (outstanding != '0);
   assign push      = resp && (discard == '0) && !redirect;

   assign fs_valid  = !empty && !redirect;
   assign pop       = fs_valid & ds_allowin & !stall_flag;

   assign pc_out    = empty ? resp_pc  : fifo_pc[rptr[AW-1:0]];
   assign inst_out  = empty ? NOP_INST : fifo_inst[rptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc    <= RESET_PC;
         resp_pc     <= RESET_PC;
         outstanding <= '0;
         discard     <= '0;
         wptr        <= '0;
         rptr        <= '0;
      end else begin
         outstanding <= outstanding + CW'(grant) - CW'(resp);
         if (redirect) begin
            fetch_pc <= target;
            resp_pc  <= target;
            wptr     <= '0;
            rptr     <= '0;
            // outstanding already includes responses still owed to earlier
            // redirects, so the new drop count is simply every request left in flight.
            discard  <= outstanding - CW'(resp);
         end else begin
            if (grant)
               fetch_pc <= fetch_pc + 32'd4;
            if (push) begin
               wptr    <= wptr + CW'(1);
               resp_pc <= resp_pc + 32'd4;
            end
            if (resp && (discard != '0))
               discard <= discard - CW'(1);
            if (pop)
               rptr <= rptr + CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_pc[wptr[AW-1:0]]   <= resp_pc;
         fifo_inst[wptr[AW-1:0]] <= imem_rdata;
      end
   end

endmodule
